// File: rtl/pcie_dispatch_pkg.sv
// Shared NoC definitions: flit field offsets and destination-index mapping
// used by the PCIe dispatcher and the PE-side blocks.
package pcie_dispatch_pkg;

   // Width of the in-flight flit counter exposed on o_outstanding.
   localparam int CNT_W = 8;

   // Flit layout, MSB to LSB: {x, y, seq, payload}; payload starts at bit 0.
   function automatic int seq_lsb(input int data_width);
      return data_width;
   endfunction

   function automatic int y_lsb(input int data_width, input int pck_num);
      return data_width + pck_num;
   endfunction

   function automatic int x_lsb(input int data_width, input int pck_num, input int y_size);
      return data_width + pck_num + y_size;
   endfunction

   // Linear node index to mesh column / row.
   function automatic int idx_to_x(input int idx, input int cols);
      return idx % cols;
   endfunction

   function automatic int idx_to_y(input int idx, input int cols);
      return idx / cols;
   endfunction

   // Next destination: walks 1..nodes-1 and skips node 0 (the PCIe bridge).
   function automatic int next_idx(input int idx, input int nodes);
      return (idx >= nodes - 1) ? 1 : idx + 1;
   endfunction

endpackage

// File: rtl/pcie_dispatch_credit.sv
// Outstanding-flit counter: counts accepted flits not yet answered by a
// returned DCT result, and flags when the in-flight limit is reached.
module dispatch_credit
   import pcie_dispatch_pkg::*;
#(
   parameter int MAX_OUT = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             dec_eff;

   // A returned result with nothing in flight cannot belong to any flit.
   assign dec_eff = dec_i && (count_q != '0);

   // Next count: a simultaneous accept and return cancel out.
   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      unique case ({inc_i, dec_eff})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Counter register.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: non-blocking assignments keep register updates order-independent.
      if (!rstn) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;
   assign full_o  = (count_q >= CNT_W'(MAX_OUT));

endmodule

// File: rtl/pcie_dispatch.sv
// PCIe-to-NoC dispatcher: stamps each PCIe payload word with a round-robin
// PE destination and a sequence number, presents it through a single
// output register, and throttles input by the number of flits in flight.
module pcie_dispatch
   import pcie_dispatch_pkg::*;
#(
   parameter int X           = 8,
   parameter int Y           = 8,
   parameter int pck_num     = 12,
   parameter int data_width  = 256,
   parameter int x_size      = $clog2(X),
   parameter int y_size      = $clog2(Y),
   parameter int total_width = x_size + y_size + pck_num + data_width,
   parameter int MAX_OUT     = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_valid,
   input  logic [data_width-1:0]  i_data,
   output logic                   o_ready,
   output logic                   o_valid,
   output logic [total_width-1:0] o_data,
   input  logic                   i_ready,
   input  logic                   i_done,
   output logic [CNT_W-1:0]       o_outstanding
);

   localparam int NODES   = X * Y;
   localparam int IDX_W   = $clog2(NODES);
   localparam int SEQ_LSB = seq_lsb(data_width);
   localparam int Y_LSB   = y_lsb(data_width, pck_num);
   localparam int X_LSB   = x_lsb(data_width, pck_num, y_size);

   logic                   valid_q, valid_d;
   logic [total_width-1:0] data_q, data_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [pck_num-1:0]     seq_q, seq_d;
   logic                   full;
   logic                   accept;

   // Ready depends only on registered state and i_ready; held low in reset.
   assign o_ready = rstn && (!valid_q || i_ready) && !full;
   assign accept  = i_valid && o_ready;

   dispatch_credit #(
      .MAX_OUT (MAX_OUT)
   ) u_credit (
      .clk     (clk),
      .rstn    (rstn),
      .inc_i   (accept),
      .dec_i   (i_done),
      .count_o (o_outstanding),
      .full_o  (full)
   );

   // Next flit: load on accept, otherwise drop valid once downstream takes it.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      if (accept) begin
         valid_d                        = 1'b1;
         data_d[data_width-1:0]         = i_data;
         data_d[SEQ_LSB +: pck_num]     = seq_q;
         data_d[Y_LSB +: y_size]        = y_size'(idx_to_y(int'(idx_q), X));
         data_d[X_LSB +: x_size]        = x_size'(idx_to_x(int'(idx_q), X));
         idx_d                          = IDX_W'(next_idx(int'(idx_q), NODES));
         seq_d                          = seq_q + 1'b1;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register and destination / sequence counters.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         // NOTE: the wide payload register is reset only because o_data must read 0 in reset.
         data_q  <= '0;
         idx_q   <= IDX_W'(1);
         seq_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         seq_q   <= seq_d;
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

endmodule

// File: tb/tb_pcie_dispatch.sv
// Scoreboard bench for pcie_dispatch with a small mesh, short sequence
// numbers and a low in-flight limit so wrap-around and throttling occur often.
module tb_pcie_dispatch;

   localparam int X  = 4;
   localparam int Y  = 2;
   localparam int PN = 4;
   localparam int DW = 16;
   localparam int MO = 4;
   localparam int XS = $clog2(X);
   localparam int YS = $clog2(Y);
   localparam int TW = XS + YS + PN + DW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_ready;
   logic          o_valid;
   logic [TW-1:0] o_data;
   logic          i_ready;
   logic          i_done;
   logic [7:0]    o_outstanding;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: flits owed to the output, next destination,
   // next sequence number and flits in flight.
   logic [TW-1:0] exp_q[$];
   int            m_idx = 1;
   int            m_seq = 0;
   int            m_cnt = 0;

   pcie_dispatch #(
      .X          (X),
      .Y          (Y),
      .pck_num    (PN),
      .data_width (DW),
      .MAX_OUT    (MO)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_valid       (i_valid),
      .i_data        (i_data),
      .o_ready       (o_ready),
      .o_valid       (o_valid),
      .o_data        (o_data),
      .i_ready       (i_ready),
      .i_done        (i_done),
      .o_outstanding (o_outstanding)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [TW-1:0] make_flit(input int idx, input int seq, input logic [DW-1:0] data);
      logic [TW-1:0] f;
      f = TW'(idx % X) << (YS + PN + DW);
      f = f | (TW'(idx / X) << (PN + DW));
      f = f | (TW'(seq) << DW);
      f = f | TW'(data);
      return f;
   endfunction

   // Monitor: compares DUT outputs to the model mid-cycle, then advances the
   // model to what the coming rising edge should do.
   initial begin
      logic          exp_ready;
      logic [TW-1:0] dummy;
      bit            acc;
      bit            dec;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            check("rst_o_valid", o_valid, 0);
            check("rst_o_data", o_data, 0);
            check("rst_o_ready", o_ready, 0);
            check("rst_outstanding", o_outstanding, 0);
            exp_q.delete();
            m_idx = 1;
            m_seq = 0;
            m_cnt = 0;
         end else begin
            check("o_valid", o_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("o_data", o_data, exp_q[0]);
            exp_ready = ((exp_q.size() == 0) || i_ready) && (m_cnt < MO);
            check("o_ready", o_ready, exp_ready);
            check("outstanding", o_outstanding, m_cnt);
            if (exp_q.size() > 0 && i_ready) dummy = exp_q.pop_front();
            acc = i_valid && exp_ready;
            if (acc) begin
               exp_q.push_back(make_flit(m_idx, m_seq, i_data));
               m_idx = (m_idx == X * Y - 1) ? 1 : m_idx + 1;
               m_seq = (m_seq + 1) % (1 << PN);
            end
            dec = i_done && (m_cnt > 0);
            if (acc && !dec) m_cnt++;
            else if (dec && !acc) m_cnt--;
         end
      end
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic step(input logic v, input logic r, input logic d);
      @(posedge clk);
      #1;
      i_valid = v;
      i_ready = r;
      i_done  = d;
      i_data  = DW'($urandom);
   endtask

   initial begin
      rstn    = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_done  = 1'b0;
      i_data  = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // Three words, downstream ready: destinations 1,2,3 on row 0.
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b1, 1'b0);

      // Downstream stalled for five cycles while a flit is held.
      repeat (5) step(1'b1, 1'b0, 1'b0);

      // Drain, then return more results than are in flight.
      step(1'b0, 1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b1, 1'b1);

      // Fill to the limit with no results, then release one credit.
      repeat (8) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b1, 1'b1);

      // Randomized traffic with back-pressure and returns.
      repeat (500) step($urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(3) == 0);

      // Reset in the middle of a stream; outputs must drop immediately.
      repeat (3) step(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1 rstn = 1'b0;
      #1 check("rst_async_o_valid", o_valid, 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      repeat (300) step($urandom_range(9) < 8, $urandom_range(9) < 8, $urandom_range(2) == 0);

      // Drain everything still owed.
      repeat (10) step(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #1 check("drain_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
